demux_1to7_32b_reg: RTL and testbench

- Registered 1-to-7 distributor: the inverse of the 7-to-1 functional-unit input mux.
- Steers one 32-bit input word to one of seven output ports, chosen by a 3-bit select from the configuration bits.
- Each output port has a single-entry holding register with a valid/ready handshake, so a stalled consumer does not block the other six outputs.
- Sits on the CGRA interconnect where one PE output fans out to neighbouring PEs.

---
 rtl/demux_1to7_32b_reg.sv | 71 +++++++
 tb/tb_demux_1to7_32b_reg.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1to7_32b_reg.sv
// Registered 1-to-7 distributor: steers one input word into one of seven
// single-entry holding registers (valid/ready per port) or discards it.
module demux_1to7_32b_reg #(
    parameter int size           = 32,
    parameter int drop_cnt_width = 8
) (
    input  logic                      CGRA_Clock,
    input  logic                      CGRA_Reset,
    input  logic [size-1:0]           in,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                select,
    output logic [size-1:0]           out0,
    output logic [size-1:0]           out1,
    output logic [size-1:0]           out2,
    output logic [size-1:0]           out3,
    output logic [size-1:0]           out4,
    output logic [size-1:0]           out5,
    output logic [size-1:0]           out6,
    output logic [6:0]                out_valid,
    input  logic [6:0]                out_ready,
    output logic [drop_cnt_width-1:0] drop_count
);

    logic [size-1:0] hold [7];
    logic [7:0]      room;
    logic            accept;
    logic [6:0]      load;

    // Bit 7 of room is the discard slot, which always has space.
    always_comb begin
        room     = {1'b1, ~out_valid | out_ready};
        in_ready = room[select];
        accept   = in_valid && in_ready;
        load     = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            load[i] = accept && (select == 3'(i));
        end
    end

    always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
        if (CGRA_Reset) begin
            out_valid  <= '0;
            drop_count <= '0;
            for (int unsigned i = 0; i < 7; i++) begin
                hold[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 7; i++) begin
                if (load[i]) begin
                    hold[i]      <= in;
                    out_valid[i] <= 1'b1;
                end else if (out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
            if (accept && (select == 3'd7) && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

    assign out0 = hold[0];
    assign out1 = hold[1];
    assign out2 = hold[2];
    assign out3 = hold[3];
    assign out4 = hold[4];
    assign out5 = hold[5];
    assign out6 = hold[6];

endmodule

// File: tb/tb_demux_1to7_32b_reg.sv
// Bench for demux_1to7_32b_reg: directed scenarios plus constrained-random
// traffic, compared against a per-port queue model.
module tb_demux_1to7_32b_reg;

    logic        clk;
    logic        rst;
    logic [31:0] d_in;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  sel;
    logic [31:0] out0, out1, out2, out3, out4, out5, out6;
    logic [6:0]  out_valid;
    logic [6:0]  out_ready;
    logic [7:0]  drop_count;
    logic [31:0] dut_out [7];

    int vectors;
    int miscompares;

    // Model: each port is a queue of at most one word; last[] is what the
    // port register shows (it keeps its data after a drain).
    logic [31:0] port_q [7][$];
    logic [31:0] last [7];
    int          drops;

    demux_1to7_32b_reg #(.size(32), .drop_cnt_width(8)) dut (
        .CGRA_Clock(clk),
        .CGRA_Reset(rst),
        .in(d_in),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .select(sel),
        .out0(out0),
        .out1(out1),
        .out2(out2),
        .out3(out3),
        .out4(out4),
        .out5(out5),
        .out6(out6),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .drop_count(drop_count)
    );

    always_comb begin
        dut_out[0] = out0;
        dut_out[1] = out1;
        dut_out[2] = out2;
        dut_out[3] = out3;
        dut_out[4] = out4;
        dut_out[5] = out5;
        dut_out[6] = out6;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit model_ready(input logic [2:0] s, input logic [6:0] rdy);
        if (s == 3'd7) return 1'b1;
        return (port_q[s].size() == 0) || rdy[s];
    endfunction

    function automatic logic [6:0] model_valid();
        logic [6:0] v;
        for (int i = 0; i < 7; i++) v[i] = (port_q[i].size() != 0);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 7; i++) begin
            port_q[i].delete();
            last[i] = '0;
        end
        drops = 0;
    endtask

    // One clock: sample inputs before the edge, advance the model, settle.
    task automatic tick();
        bit          acc;
        logic [2:0]  s;
        logic [31:0] w;
        logic [6:0]  rdy;
        s   = sel;
        w   = d_in;
        rdy = out_ready;
        acc = in_valid && model_ready(s, rdy);
        @(posedge clk);
        for (int i = 0; i < 7; i++) begin
            if (rdy[i] && port_q[i].size() != 0) void'(port_q[i].pop_front());
        end
        if (acc && s != 3'd7) begin
            port_q[s].push_back(w);
            last[s] = w;
        end
        if (acc && s == 3'd7 && drops < 255) drops++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 0; d_in = '0; sel = '0; out_ready = '0;
        model_reset();
        #12;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 7'b0 || drop_count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_idle: out_valid=%b drop=%0d, want 0/0", out_valid, drop_count);
        end
        // Fill ports 0 and 2, then reset mid-cycle.
        in_valid = 1; sel = 3'd0; d_in = $urandom; tick();
        sel = 3'd2; d_in = $urandom; tick();
        in_valid = 0;
        vectors++;
        if (out_valid !== 7'b0000101) begin
            miscompares++;
            $display("FAIL pre_reset_valid: out_valid=%b, want 0000101", out_valid);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (out_valid !== 7'b0 || drop_count !== 8'd0) begin
            miscompares++;
            $display("FAIL async_reset: out_valid=%b drop=%0d, want 0/0", out_valid, drop_count);
        end
        for (int i = 0; i < 7; i++) begin
            vectors++;
            if (dut_out[i] !== 32'h0) begin
                miscompares++;
                $display("FAIL async_reset_out%0d: got %h, want 0", i, dut_out[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_route();
        out_ready = '0;
        sel = 3'd3; d_in = 32'hDEADBEEF; in_valid = 1;
        tick();
        in_valid = 0;
        vectors++;
        if (out3 !== 32'hDEADBEEF || out_valid !== 7'b0001000) begin
            miscompares++;
            $display("FAIL single_route: out3=%h valid=%b, want deadbeef/0001000", out3, out_valid);
        end
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL single_ready_full: in_ready=%b, want 0", in_ready);
        end
        sel = 3'd4; #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_ready_other: in_ready=%b, want 1", in_ready);
        end
    endtask

    task automatic test_backpressure();
        out_ready = '0;
        sel = 3'd3; d_in = 32'h12345678; in_valid = 1;
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) out_ready[3] = 1'b1;
            #1;
            vectors++;
            if (in_ready !== (c == 5)) begin
                miscompares++;
                $display("FAIL backpressure_c%0d: in_ready=%b, want %0d", c, in_ready, (c == 5));
            end
            tick();
        end
        in_valid = 0; out_ready = '0;
        vectors++;
        if (out3 !== 32'h12345678 || out_valid[3] !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure_release: out3=%h v=%b, want 12345678/1", out3, out_valid[3]);
        end
    endtask

    task automatic test_streaming();
        sel = 3'd0; out_ready = 7'b0000001; in_valid = 1;
        for (int k = 1; k <= 4; k++) begin
            d_in = k;
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL stream_ready_%0d: in_ready=%b, want 1", k, in_ready);
            end
            tick();
            vectors++;
            if (out0 !== 32'(k) || out_valid[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL stream_data_%0d: out0=%h v=%b, want %h/1", k, out0, out_valid[0], 32'(k));
            end
        end
        in_valid = 0;
        tick();
        vectors++;
        if (out_valid[0] !== 1'b0 || out0 !== 32'd4) begin
            miscompares++;
            $display("FAIL stream_drain: v=%b out0=%h, want 0/4", out_valid[0], out0);
        end
        out_ready = '0;
    endtask

    task automatic test_independent();
        logic [31:0] w6;
        out_ready = '0;
        w6 = $urandom;
        sel = 3'd6; d_in = w6; in_valid = 1; tick();
        sel = 3'd1; d_in = 32'hA5; tick();
        in_valid = 0;
        vectors++;
        if (out1 !== 32'hA5 || out_valid[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL indep_port1: out1=%h v=%b, want a5/1", out1, out_valid[1]);
        end
        vectors++;
        if (out6 !== w6 || out_valid[6] !== 1'b1) begin
            miscompares++;
            $display("FAIL indep_port6: out6=%h v=%b, want %h/1", out6, out_valid[6], w6);
        end
    endtask

    task automatic test_random();
        bit pending;
        pending = 0;
        for (int n = 0; n < 400; n++) begin
            // Producer holds word and select while a word is pending.
            if (!pending) begin
                in_valid = ($urandom_range(0, 3) != 0);
                sel      = 3'($urandom_range(0, 7));
                d_in     = $urandom;
            end
            out_ready = 7'($urandom);
            #1;
            vectors++;
            if (in_ready !== model_ready(sel, out_ready)) begin
                miscompares++;
                $display("FAIL rand_ready_%0d: in_ready=%b, want %b", n, in_ready, model_ready(sel, out_ready));
            end
            pending = in_valid && !model_ready(sel, out_ready);
            tick();
            vectors++;
            if (out_valid !== model_valid() || drop_count !== 8'(drops)) begin
                miscompares++;
                $display("FAIL rand_state_%0d: valid=%b drop=%0d, want %b/%0d", n, out_valid, drop_count, model_valid(), drops);
            end
            for (int i = 0; i < 7; i++) begin
                vectors++;
                if (dut_out[i] !== last[i]) begin
                    miscompares++;
                    $display("FAIL rand_out%0d_%0d: got %h, want %h", i, n, dut_out[i], last[i]);
                end
            end
        end
        in_valid = 0; out_ready = '0;
        tick();
    endtask

    task automatic test_discard();
        logic [6:0] v0;
        int         bad;
        out_ready = '0;
        v0 = out_valid;
        bad = 0;
        sel = 3'd7; in_valid = 1;
        for (int n = 0; n < 300; n++) begin
            d_in = $urandom;
            #1;
            if (in_ready !== 1'b1) bad++;
            tick();
            if (out_valid !== v0 || drop_count !== 8'(drops)) bad++;
        end
        in_valid = 0;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL discard_stream: %0d bad cycles, want 0", bad);
        end
        vectors++;
        if (drop_count !== 8'd255) begin
            miscompares++;
            $display("FAIL discard_saturate: drop=%0d, want 255", drop_count);
        end
        tick();
        vectors++;
        if (drop_count !== 8'd255) begin
            miscompares++;
            $display("FAIL discard_idle_hold: drop=%0d, want 255", drop_count);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_single_route();
        test_backpressure();
        test_streaming();
        test_independent();
        test_random();
        test_discard();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
